// File: rtl/fetch_pkg.sv
// Shared constants and types for the RAT MCU fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned INSTR_W = 18;

    localparam logic [ADDR_W-1:0] RESET_PC = 10'h000;
    localparam logic [ADDR_W-1:0] INTR_VEC = 10'h3FF;

    typedef enum logic [1:0] {
        RUN,
        VECT,
        WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic               valid;
    } fetch_out_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter, in-flight ROM request tracking and ROM address select.
module fetch_pc_gen
    import fetch_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_addr,
    input  logic              i_intr_take,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic [ADDR_W-1:0] o_req_pc,
    output logic              o_req_vld
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_req_vld;
    logic              w_jump;
    logic [ADDR_W-1:0] w_target;

    // Interrupt take is only raised when no redirect is present.
    assign w_jump   = i_redirect | i_intr_take;
    assign w_target = i_redirect ? i_redirect_addr : INTR_VEC;

    // While stalled, re-read the in-flight address so ROM data stays coherent.
    always_comb begin
        o_rom_addr = r_pc;
        if (w_jump) begin
            o_rom_addr = w_target;
        end else if (i_stall) begin
            o_rom_addr = r_req_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc      <= RESET_PC;
            r_req_pc  <= RESET_PC;
            r_req_vld <= 1'b0;
        end else if (w_jump) begin
            r_pc      <= w_target + ADDR_W'(1);
            r_req_pc  <= w_target;
            r_req_vld <= 1'b1;
        end else if (!i_stall) begin
            r_pc      <= r_pc + ADDR_W'(1);
            r_req_pc  <= r_pc;
            r_req_vld <= 1'b1;
        end
    end

    assign o_req_pc  = r_req_pc;
    assign o_req_vld = r_req_vld;

endmodule

// File: rtl/fetch_stage.sv
// RAT MCU instruction fetch: output register, interrupt vectoring FSM and
// optional stall/flush counters (enabled by defining FETCH_PERF_CNT_EN).
module fetch_stage
    import fetch_pkg::*;
(
    input  logic               FCH_CLK,
    input  logic               FCH_RST_N,
    input  logic               FCH_STALL,
    input  logic               FCH_REDIRECT,
    input  logic [ADDR_W-1:0]  FCH_REDIRECT_ADDR,
    input  logic               FCH_INTR,
    input  logic [INSTR_W-1:0] FCH_ROM_DATA,
    output logic [ADDR_W-1:0]  FCH_ROM_ADDR,
    output logic [INSTR_W-1:0] FCH_INSTR,
    output logic [ADDR_W-1:0]  FCH_PC,
    output logic [ADDR_W-1:0]  FCH_RET_PC,
    output logic               FCH_VALID,
    output logic               FCH_INTR_ACK,
    output logic [ADDR_W-1:0]  FCH_INTR_RET,
    output logic [15:0]        FCH_STALL_CNT,
    output logic [15:0]        FCH_FLUSH_CNT
);

    fetch_state_t      r_state;
    fetch_out_t        r_out;
    logic [ADDR_W-1:0] w_req_pc;
    logic              w_req_vld;
    logic              w_take;

    // Never take on a bubble: the return address must name a real instruction.
    assign w_take = FCH_INTR & ~FCH_REDIRECT & ~FCH_STALL & w_req_vld & (r_state == RUN);

    fetch_pc_gen u_pc_gen (
        .i_clk           (FCH_CLK),
        .i_rst_n         (FCH_RST_N),
        .i_stall         (FCH_STALL),
        .i_redirect      (FCH_REDIRECT),
        .i_redirect_addr (FCH_REDIRECT_ADDR),
        .i_intr_take     (w_take),
        .o_rom_addr      (FCH_ROM_ADDR),
        .o_req_pc        (w_req_pc),
        .o_req_vld       (w_req_vld)
    );

    always_ff @(posedge FCH_CLK or negedge FCH_RST_N) begin
        if (!FCH_RST_N) begin
            r_state <= RUN;
        end else begin
            unique case (r_state)
                RUN:     if (w_take) r_state <= VECT;
                VECT:    r_state <= WAIT;
                WAIT:    if (!FCH_INTR) r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    always_ff @(posedge FCH_CLK or negedge FCH_RST_N) begin
        if (!FCH_RST_N) begin
            r_out <= '0;
        end else if (FCH_REDIRECT || w_take) begin
            r_out.valid <= 1'b0;
        end else if (!FCH_STALL) begin
            r_out <= '{instr: FCH_ROM_DATA, pc: w_req_pc, valid: w_req_vld};
        end
    end

    assign FCH_INSTR    = r_out.instr;
    assign FCH_PC       = r_out.pc;
    assign FCH_VALID    = r_out.valid;
    assign FCH_RET_PC   = r_out.pc + ADDR_W'(1);
    assign FCH_INTR_ACK = w_take;
    assign FCH_INTR_RET = w_req_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge FCH_CLK or negedge FCH_RST_N) begin
        if (!FCH_RST_N) begin
            r_stall_cnt <= 16'h0000;
            r_flush_cnt <= 16'h0000;
        end else begin
            if (FCH_STALL && !FCH_REDIRECT && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'h0001;
            end
            if ((FCH_REDIRECT || w_take) && r_flush_cnt != 16'hFFFF) begin
                r_flush_cnt <= r_flush_cnt + 16'h0001;
            end
        end
    end

    assign FCH_STALL_CNT = r_stall_cnt;
    assign FCH_FLUSH_CNT = r_flush_cnt;
`else
    assign FCH_STALL_CNT = 16'h0000;
    assign FCH_FLUSH_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected PCs queued as stimulus is driven,
// popped whenever a new valid instruction reaches the outputs.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               stall = 1'b0;
    logic               redirect = 1'b0;
    logic [ADDR_W-1:0]  redirect_addr = '0;
    logic               intr = 1'b0;
    logic [INSTR_W-1:0] rom_data = '0;
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  ret_pc;
    logic               valid;
    logic               ack;
    logic [ADDR_W-1:0]  intr_ret;
    logic [15:0]        stall_cnt;
    logic [15:0]        flush_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [ADDR_W-1:0] exp_q[$];

    fetch_stage dut (
        .FCH_CLK           (clk),
        .FCH_RST_N         (rst_n),
        .FCH_STALL         (stall),
        .FCH_REDIRECT      (redirect),
        .FCH_REDIRECT_ADDR (redirect_addr),
        .FCH_INTR          (intr),
        .FCH_ROM_DATA      (rom_data),
        .FCH_ROM_ADDR      (rom_addr),
        .FCH_INSTR         (instr),
        .FCH_PC            (pc),
        .FCH_RET_PC        (ret_pc),
        .FCH_VALID         (valid),
        .FCH_INTR_ACK      (ack),
        .FCH_INTR_RET      (intr_ret),
        .FCH_STALL_CNT     (stall_cnt),
        .FCH_FLUSH_CNT     (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
        return {8'h2D, a};
    endfunction

    // Synchronous ROM, one-cycle read latency
    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_range(input logic [ADDR_W-1:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + ADDR_W'(i));
    endtask

    task automatic wait_pc(input logic [ADDR_W-1:0] t);
        int i;
        for (i = 0; i < 300 && !(valid && pc == t); i++) @(negedge clk);
        if (!(valid && pc == t)) chk("wait_pc_timeout", {22'b0, pc}, {22'b0, t});
    endtask

    // A new output slot exists after an edge that was not a plain stall.
    always @(posedge clk) begin : mon
        logic              adv;
        logic [ADDR_W-1:0] e;
        adv = rst_n && (!stall || redirect || ack);
        #1;
        if (adv && valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pc", {22'b0, pc}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", {22'b0, pc}, {22'b0, e});
                chk("sb_instr", {14'b0, instr}, {14'b0, rom_fn(e)});
                chk("sb_ret_pc", {22'b0, ret_pc}, {22'b0, e + ADDR_W'(1)});
            end
        end
    end

    initial begin
        #1;
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_rom_addr", {22'b0, rom_addr}, {22'b0, RESET_PC});
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_pc", {22'b0, pc}, 32'd0);
        chk("rst_instr", {14'b0, instr}, 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push_range(10'h000, 6);
        @(negedge clk);
        chk("first_edge_valid", {31'b0, valid}, 32'd0);
        @(negedge clk);
        chk("second_edge_valid", {31'b0, valid}, 32'd1);
        chk("second_edge_pc", {22'b0, pc}, 32'h000);

        // Stall for three cycles at PC 0x005
        wait_pc(10'h005);
        stall = 1'b1;
        #1 chk("stall_rom_addr", {22'b0, rom_addr}, 32'h006);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_pc_hold", {22'b0, pc}, 32'h005);
            chk("stall_valid_hold", {31'b0, valid}, 32'd1);
            chk("stall_rom_addr", {22'b0, rom_addr}, 32'h006);
        end
        stall = 1'b0;
        push_range(10'h006, 11);
        @(negedge clk);
        chk("stall_release_pc", {22'b0, pc}, 32'h006);

        // Redirect with a simultaneous stall that must be ignored
        wait_pc(10'h010);
        redirect = 1'b1;
        redirect_addr = 10'h120;
        stall = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        stall = 1'b0;
        chk("redirect_bubble", {31'b0, valid}, 32'd0);
        push_range(10'h120, 5);
        @(negedge clk);
        chk("redirect_target_pc", {22'b0, pc}, 32'h120);
        chk("redirect_target_valid", {31'b0, valid}, 32'd1);
        @(negedge clk);
        chk("redirect_next_pc", {22'b0, pc}, 32'h121);

        wait_pc(10'h124);
        redirect = 1'b1;
        redirect_addr = 10'h02C;
        @(negedge clk);
        redirect = 1'b0;
        push_range(10'h02C, 5);

        // Interrupt at PC 0x030 with 0x031 in flight
        wait_pc(10'h030);
        intr = 1'b1;
        #1;
        chk("intr_ack", {31'b0, ack}, 32'd1);
        chk("intr_ret", {22'b0, intr_ret}, 32'h031);
        exp_q.push_back(INTR_VEC);
        push_range(10'h000, 9);
        @(negedge clk);
        chk("intr_ack_pulse", {31'b0, ack}, 32'd0);
        chk("intr_bubble", {31'b0, valid}, 32'd0);
        @(negedge clk);
        chk("intr_vec_pc", {22'b0, pc}, {22'b0, INTR_VEC});
        chk("wrap_ret_pc", {22'b0, ret_pc}, 32'h000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("intr_held_no_ack", {31'b0, ack}, 32'd0);
        end
        intr = 1'b0;

        // After the request drops, a new one is taken again
        wait_pc(10'h008);
        intr = 1'b1;
        #1;
        chk("intr2_ack", {31'b0, ack}, 32'd1);
        chk("intr2_ret", {22'b0, intr_ret}, 32'h009);
        exp_q.push_back(INTR_VEC);
        push_range(10'h000, 'h45);
        @(negedge clk);
        intr = 1'b0;
        chk("intr2_bubble", {31'b0, valid}, 32'd0);

        wait_pc(10'h044);
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt", {16'b0, stall_cnt}, 32'd3);
        chk("flush_cnt", {16'b0, flush_cnt}, 32'd4);
`else
        chk("stall_cnt_tied", {16'b0, stall_cnt}, 32'd0);
        chk("flush_cnt_tied", {16'b0, flush_cnt}, 32'd0);
`endif
        chk("sb_drained_pre_rst", exp_q.size(), 32'd0);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, valid}, 32'd0);
        chk("async_rst_rom_addr", {22'b0, rom_addr}, 32'h000);
        chk("async_rst_ack", {31'b0, ack}, 32'd0);
        chk("async_rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
        chk("async_rst_flush_cnt", {16'b0, flush_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_range(10'h000, 4);
        wait_pc(10'h003);
        chk("sb_drained_end", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
